// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard MMIO receiver.
//   ps2_state_e - receiver FSM states (IDLE, RECV, CHECK)
//   FRAME_BITS  - bits per PS/2 frame (start, 8 data, parity, stop)
//   OFS_*       - register byte offsets from BASE_ADDR
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } ps2_state_e;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned CODE_W     = 8;

   localparam int unsigned OFS_DATA   = 0;
   localparam int unsigned OFS_STATUS = 4;
   localparam int unsigned OFS_ERRCNT = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head output.
//   clock, reset : system clock, synchronous active-high reset
//   push, wdata  : write request and data (accepted if not full, or if popping)
//   pop          : read request (ignored when empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags; count: number of stored entries
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             empty_q;
   logic             do_push;
   logic             do_pop;

   // A pop on a full FIFO frees the slot the simultaneous push needs;
   // a push into an empty FIFO is not visible to a same-cycle pop.
   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = empty_q;
   assign do_pop  = pop & ~empty_q;
   assign do_push = push & (~full | do_pop);
   assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt_q;

   // Pointers, occupancy and empty flag
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
      end
   end

   // Storage array
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ps2_kbd_mmio.sv
// ps2_kbd_mmio: memory-mapped PS/2 keyboard receiver.
//   clock, reset       : system clock, synchronous active-high reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 pins
//   addr, rd_en        : CPU load address and strobe
//   rdata              : registered read data (1-cycle latency, holds on non-hit)
//   kbd_ready          : scan-code FIFO non-empty
//   overflow           : sticky, a good code was dropped on a full FIFO
// Registers: DATA @BASE_ADDR (pops), STATUS @BASE_ADDR+4 (clears overflow),
// ERRCNT @BASE_ADDR+8 only when PS2_ERRCNT_EN is defined (clear-on-read).
module ps2_kbd_mmio
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic [31:0] addr,
   input  logic        rd_en,
   output logic [31:0] rdata,
   output logic        kbd_ready,
   output logic        overflow
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BW = $clog2(FRAME_BITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic                  clk_s1, clk_s2, clk_prev;
   logic                  dat_s1, dat_s2;
   logic                  fall;

   ps2_state_e            state_q, state_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [TW-1:0]         tmo_q, tmo_d;

   logic                  in_check;
   logic                  frame_good;
   logic                  push;
   logic                  ovf_set;
   logic                  hit_data, hit_status;
   logic [CODE_W-1:0]     fifo_head;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;

   // Pin synchronisers; idle-high reset value avoids a false edge after reset
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   // Receiver state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tmo_q     <= tmo_d;
      end
   end

   // Receiver next-state; bits enter at the MSB so the frame ends LSB-aligned
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tmo_d     = tmo_q;
      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (fall && !dat_s2) begin
               state_d   = RECV;
               bit_cnt_d = BW'(1);
               shift_d   = {dat_s2, shift_q[FRAME_BITS-1:1]};
            end
         end
         RECV: begin
            if (fall) begin
               shift_d   = {dat_s2, shift_q[FRAME_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BW'(1);
               tmo_d     = '0;
               if (bit_cnt_q == BW'(FRAME_BITS - 1)) state_d = CHECK;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               shift_d   = '0;
               tmo_d     = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         CHECK: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame check: start=0 (guaranteed by IDLE entry), stop=1, odd parity
   assign in_check   = (state_q == CHECK);
   assign frame_good = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
   assign push       = in_check & frame_good;

   assign hit_data   = rd_en & (addr == (BASE_ADDR + 32'(OFS_DATA)));
   assign hit_status = rd_en & (addr == (BASE_ADDR + 32'(OFS_STATUS)));
   // A same-cycle DATA pop frees a slot, so only a non-popping push overflows
   assign ovf_set    = push & fifo_full & ~hit_data;

   sync_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (hit_data),
      .wdata (shift_q[8:1]),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign kbd_ready = ~fifo_empty;

`ifdef PS2_ERRCNT_EN
   logic       hit_err;
   logic [7:0] errcnt_q;

   assign hit_err = rd_en & (addr == (BASE_ADDR + 32'(OFS_ERRCNT)));

   // Saturating bad-frame counter; an increment beats a clearing read
   always_ff @(posedge clock) begin
      if (reset) begin
         errcnt_q <= '0;
      end else if (in_check && !frame_good) begin
         if (hit_err)                errcnt_q <= 8'd1;
         else if (errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
      end else if (hit_err) begin
         errcnt_q <= '0;
      end
   end
`endif

   // Read data register and sticky overflow
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata    <= '0;
         overflow <= 1'b0;
      end else begin
         if (hit_data) begin
            rdata <= fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_head};
         end else if (hit_status) begin
            rdata <= {22'b0, overflow, 1'b0, 8'(fifo_count)};
`ifdef PS2_ERRCNT_EN
         end else if (hit_err) begin
            rdata <= {24'b0, errcnt_q};
`endif
         end
         if (ovf_set)         overflow <= 1'b1;
         else if (hit_status) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// tb_ps2_kbd_mmio: self-checking bench for ps2_kbd_mmio with a queue-based
// reference model. Honours PS2_ERRCNT_EN the same way as the design.
module tb_ps2_kbd_mmio;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned TMO    = 300;
   localparam logic [31:0] BASE   = 32'h0020_0000;
   localparam logic [31:0] A_DATA = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'd4;
   localparam logic [31:0] A_ERR  = BASE + 32'd8;
   localparam logic [31:0] A_NONE = BASE + 32'd12;

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] addr     = 32'h0;
   logic        rd_en    = 1'b0;
   logic [31:0] rdata;
   logic        kbd_ready;
   logic        overflow;

   int vectors = 0;
   int errors  = 0;

   // Reference model state
   logic [7:0]  mq[$];
   bit          m_ovf;
   int          m_err;
   logic [31:0] m_rdata;

   ps2_kbd_mmio #(
      .FIFO_DEPTH  (DEPTH),
      .BASE_ADDR   (BASE),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .addr      (addr),
      .rd_en     (rd_en),
      .rdata     (rdata),
      .kbd_ready (kbd_ready),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par,
                                             input bit bad_stop);
      logic [10:0] f;
      f[0]   = 1'b0;
      f[8:1] = d;
      f[9]   = ~(^d) ^ bad_par;
      f[10]  = ~bad_stop;
      return f;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_ovf   = 0;
      m_err   = 0;
      m_rdata = 32'h0;
   endtask

   task automatic model_frame(input logic [10:0] f);
      bit good;
      good = (f[0] == 1'b0) && f[10] && ($countones(f[9:1]) % 2 == 1);
      if (good) begin
         if (mq.size() < DEPTH) mq.push_back(f[8:1]);
         else                   m_ovf = 1;
      end else if (m_err < 255) begin
         m_err++;
      end
   endtask

   task automatic model_read(input logic [31:0] a, output logic [31:0] exp);
      if (a == A_DATA) begin
         exp = (mq.size() > 0) ? (32'h100 + 32'(mq.pop_front())) : 32'h0;
      end else if (a == A_STAT) begin
         exp   = (m_ovf ? 32'h200 : 32'h0) + 32'(mq.size());
         m_ovf = 0;
`ifdef PS2_ERRCNT_EN
      end else if (a == A_ERR) begin
         exp   = 32'(m_err);
         m_err = 0;
`endif
      end else begin
         exp = m_rdata;
      end
      m_rdata = exp;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd_en    = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      model_clear();
      repeat (2) @(negedge clock);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clock);
      ps2_data = b;
      repeat (4) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic send_frame(input logic [10:0] f);
      for (int i = 0; i < 11; i++) send_bit(f[i]);
      model_frame(f);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] got,
                          output logic [31:0] exp);
      @(negedge clock);
      addr  = a;
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      got   = rdata;
      model_read(a, exp);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
      end
      vectors++;
      if (kbd_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b expected 0", kbd_ready);
      end
      vectors++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_ovf: got %b expected 0", overflow);
      end
   endtask

   task automatic test_single();
      logic [31:0] got, exp;
      send_frame(make_frame(8'h1C, 0, 0));
      vectors++;
      if (kbd_ready !== 1'b1) begin
         errors++; $display("FAIL single_ready: got %b expected 1", kbd_ready);
      end
      do_read(A_DATA, got, exp);
      vectors++;
      if (got !== 32'h0000_011C) begin
         errors++; $display("FAIL single_data: got %h expected %h", got, 32'h11C);
      end
      do_read(A_DATA, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         errors++; $display("FAIL single_empty: got %h expected %h", got, 32'h0);
      end
      vectors++;
      if (kbd_ready !== 1'b0) begin
         errors++; $display("FAIL single_ready_clr: got %b expected 0", kbd_ready);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] got, exp;
      for (int i = 1; i <= 9; i++) send_frame(make_frame(8'(i), 0, 0));
      vectors++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_flag: got %b expected 1", overflow);
      end
      do_read(A_STAT, got, exp);
      vectors++;
      if (got !== 32'h0000_0208) begin
         errors++; $display("FAIL ovf_status: got %h expected %h", got, 32'h208);
      end
      for (int i = 1; i <= 8; i++) begin
         do_read(A_DATA, got, exp);
         vectors++;
         if (got !== 32'h100 + 32'(i)) begin
            errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, got, 32'h100 + 32'(i));
         end
      end
      do_read(A_STAT, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         errors++; $display("FAIL ovf_status_clr: got %h expected %h", got, 32'h0);
      end
   endtask

   task automatic test_bad_parity();
      logic [31:0] got, exp;
      send_frame(make_frame(8'h33, 0, 0));
      send_frame(make_frame(8'h44, 0, 0));
      do_read(A_STAT, got, exp);
      vectors++;
      if (got !== 32'h2) begin
         errors++; $display("FAIL bad_pre_status: got %h expected %h", got, 32'h2);
      end
      send_frame(make_frame(8'h1C, 1, 0));
      do_read(A_ERR, got, exp);
`ifdef PS2_ERRCNT_EN
      vectors++;
      if (got !== 32'h1) begin
         errors++; $display("FAIL bad_errcnt: got %h expected %h", got, 32'h1);
      end
      do_read(A_ERR, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         errors++; $display("FAIL bad_errcnt_clr: got %h expected %h", got, 32'h0);
      end
`else
      vectors++;
      if (got !== 32'h2) begin
         errors++; $display("FAIL bad_unmapped_hold: got %h expected %h", got, 32'h2);
      end
`endif
      do_read(A_DATA, got, exp);
      vectors++;
      if (got !== 32'h133) begin
         errors++; $display("FAIL bad_data0: got %h expected %h", got, 32'h133);
      end
      do_read(A_DATA, got, exp);
      vectors++;
      if (got !== 32'h144) begin
         errors++; $display("FAIL bad_data1: got %h expected %h", got, 32'h144);
      end
      vectors++;
      if (kbd_ready !== 1'b0) begin
         errors++; $display("FAIL bad_ready: got %b expected 0", kbd_ready);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] got, exp;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
      repeat (TMO + 10) @(negedge clock);
      send_frame(make_frame(8'h5A, 0, 0));
      do_read(A_DATA, got, exp);
      vectors++;
      if (got !== 32'h15A) begin
         errors++; $display("FAIL tmo_data: got %h expected %h", got, 32'h15A);
      end
`ifdef PS2_ERRCNT_EN
      do_read(A_ERR, got, exp);
      vectors++;
      if (got !== 32'h0) begin
         errors++; $display("FAIL tmo_errcnt: got %h expected %h", got, 32'h0);
      end
`endif
   endtask

   task automatic test_push_pop_full();
      logic [31:0] got, exp;
      logic [10:0] f;
      for (int i = 0; i < 8; i++) send_frame(make_frame(8'hA0 + 8'(i), 0, 0));
      f = make_frame(8'hB8, 0, 0);
      for (int i = 0; i < 10; i++) send_bit(f[i]);
      // Last bit: its falling edge reaches CHECK three cycles later; align the read
      @(negedge clock);
      ps2_data = f[10];
      repeat (4) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clock);
      addr  = A_DATA;
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      got   = rdata;
      model_read(A_DATA, exp);
      model_frame(f);
      repeat (4) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clock);
      vectors++;
      if (got !== 32'h1A0) begin
         errors++; $display("FAIL pp_head: got %h expected %h", got, 32'h1A0);
      end
      vectors++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL pp_ovf: got %b expected 0", overflow);
      end
      do_read(A_STAT, got, exp);
      vectors++;
      if (got !== 32'h8) begin
         errors++; $display("FAIL pp_status: got %h expected %h", got, 32'h8);
      end
      for (int i = 1; i <= 8; i++) begin
         do_read(A_DATA, got, exp);
         vectors++;
         if (got !== ((i == 8) ? 32'h1B8 : 32'h1A0 + 32'(i))) begin
            errors++; $display("FAIL pp_drain%0d: got %h expected %h", i, got,
                               (i == 8) ? 32'h1B8 : 32'h1A0 + 32'(i));
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] got, exp;
      logic [10:0] f;
      send_frame(make_frame(8'h77, 0, 0));
      do_read(A_STAT, got, exp);
      f = make_frame(8'hC3, 0, 0);
      for (int i = 0; i < 6; i++) send_bit(f[i]);
      do_reset();
      vectors++;
      if ({rdata, kbd_ready, overflow} !== 34'h0) begin
         errors++; $display("FAIL rstmid_outputs: got %h/%b/%b expected 0/0/0",
                            rdata, kbd_ready, overflow);
      end
      send_frame(make_frame(8'h29, 0, 0));
      do_read(A_DATA, got, exp);
      vectors++;
      if (got !== 32'h129) begin
         errors++; $display("FAIL rstmid_data: got %h expected %h", got, 32'h129);
      end
   endtask

   task automatic test_random();
      logic [31:0] got, exp;
      logic [31:0] a;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) < 3) begin
            send_frame(make_frame(8'($urandom), $urandom_range(0, 4) == 0,
                                  $urandom_range(0, 6) == 0));
         end else begin
            case ($urandom_range(0, 5))
               0, 1, 2: a = A_DATA;
               3:       a = A_STAT;
               4:       a = A_ERR;
               default: a = A_NONE;
            endcase
            do_read(a, got, exp);
            vectors++;
            if (got !== exp) begin
               errors++; $display("FAIL rand%0d_rdata @%h: got %h expected %h", n, a, got, exp);
            end
         end
         vectors++;
         if (kbd_ready !== (mq.size() != 0)) begin
            errors++; $display("FAIL rand%0d_ready: got %b expected %b", n, kbd_ready, mq.size() != 0);
         end
         vectors++;
         if (overflow !== m_ovf) begin
            errors++; $display("FAIL rand%0d_ovf: got %b expected %b", n, overflow, m_ovf);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single();
      test_overflow();
      test_bad_parity();
      test_timeout();
      test_push_pop_full();
      test_reset_midframe();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
